instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage of the MiniAlu-style processor. Holds the program counter, drives the address of the combinational instruction ROM, and registers each returned 28-bit instruction for the execute stage with a valid flag. It folds `JMP` locally, applies redirects from execute for resolved `BLE` branches, honours downstream stalls and, optionally, turns `NOP` into a timed wait.

## Interface
Parameters:
- RESET_PC, 16'd0, PC loaded on reset.

Ports:
- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- oAddress  out  16  ROM address, combinationally equal to PC register.
- iInstruction  in  28  ROM output for oAddress, valid in the same cycle.
- oInstruction  out  28  registered instruction issued to execute.
- oValid  out  1  oInstruction/oPC hold a live instruction.
- oPC  out  16  address of the instruction in oInstruction.
- iStall  in  1  execute cannot accept; hold the issued instruction.
- iBranchTaken  in  1  execute resolved a taken `BLE`; redirect.
- iBranchTarget  in  8  redirect target, zero-extended to 16 bits.

## Operation
- Instruction fields: opcode [27:24], target/destination [23:16], operands [15:8] and [7:0]. `NOP` delay count is [23:0]. Opcode values come from the shared definitions header.
- States: FETCH, WAIT. WAIT exists only with the macro.
- Priority per edge: Reset > iBranchTaken > hold > normal.
- Reset (Reset==0): PC=RESET_PC, oInstruction=0, oValid=0, oPC=0, delay counter=0, state=FETCH.
- iBranchTaken: PC=iBranchTarget zero-extended, oValid=0, state=FETCH, counter=0. The in-flight instruction is squashed. This applies in any state, including while stalled.
- Hold: iStall==1 and oValid==1. PC, oInstruction, oPC and oValid are unchanged. iStall with oValid==0 does not block loading.
- Normal, FETCH, by opcode of iInstruction:
  - `JMP`: PC=[23:16] zero-extended, oValid=0. The jump is not issued.
  - `NOP` with macro: PC=PC+1, oValid=0. If [23:0]≠0, counter=[23:0] and state=WAIT.
  - Otherwise (including `NOP` without macro, `BLE`, `STO`, `ADD`, `SUB`, `LED`): oInstruction=iInstruction, oPC=PC, oValid=1, PC=PC+1.
- WAIT: oValid=0 and counter decrements each cycle. When counter==1, return to FETCH on that edge.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 0.

## Timing
- Issue latency is 1 cycle: the instruction at PC appears on oInstruction at the next edge.
- Throughput is 1 instruction/cycle with no stalls.
- First edge with Reset==1 issues ROM[RESET_PC].
- `JMP` costs 1 bubble cycle.
- Taken branch: 1 bubble after the iBranchTaken edge, then the target instruction is issued.
- `NOP` N (macro on): exactly N+1 bubble cycles, including N=0 giving 1 bubble.
- oAddress changes only on edges.
- Reset mid-WAIT or mid-stall takes effect at that edge; counter is cleared.

## Configuration
- Macro FETCH_NOP_DELAY_EN.
- Defined: `NOP` is consumed by fetch as a wait of [23:0]+1 bubble cycles, and the WAIT state plus a 24-bit counter are present.
- Undefined: no WAIT state or counter; `NOP` is issued like any other instruction with oValid=1.

## Test plan
- Straight line: STO at 0..3, reset released at cycle 0 -> oPC 0,1,2,3 with oValid=1 on 4 consecutive edges.
- Jump: `JMP 8'd2` at 14, ADD at 13 -> oPC=13, then oValid=0 for 1 cycle, then oPC=2.
- `NOP 24'd4000` at 0:
  - Macro on: oValid=0 for 4001 cycles, then oPC=1.
  - Macro off: oPC=0 with opcode `NOP` valid on the first edge.
- Stall: iStall=1 for 3 cycles while oPC=5 is valid -> oInstruction, oPC and oAddress=6 held. Release -> oPC=6 on the next edge.
- Redirect: iBranchTaken=1 with target 8 while stalled, and separately mid-WAIT -> oValid=0 next edge, then oPC=8.
- Reset at counter=1000 in WAIT -> all outputs 0, state FETCH. First edge after release issues oPC=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and issues one registered
// instruction per cycle. Optional build macro FETCH_NOP_DELAY_EN turns NOP into a timed wait.
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'd0
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oAddress,
    input  logic [27:0] iInstruction,
    output logic [27:0] oInstruction,
    output logic        oValid,
    output logic [15:0] oPC,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [7:0]  iBranchTarget
);

    localparam logic [3:0] OP_JMP = 4'd5;

`ifdef FETCH_NOP_DELAY_EN
    localparam logic [3:0] OP_NOP = 4'd0;

    typedef enum logic {
        S_FETCH,
        S_WAIT
    } state_t;

    state_t      state, state_next;
    logic [23:0] count, count_next;
`endif

    logic [15:0] pc, pc_next;
    logic [27:0] instr_next;
    logic        valid_next;
    logic [15:0] opc_next;

    assign oAddress = pc;

    // NOTE: every signal gets its hold value before any branch, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        pc_next    = pc;
        instr_next = oInstruction;
        valid_next = oValid;
        opc_next   = oPC;
`ifdef FETCH_NOP_DELAY_EN
        state_next = state;
        count_next = count;
`endif
        if (iBranchTaken) begin
            // Squash whatever is issued, stalled or not, and restart at the branch target.
            pc_next    = {8'd0, iBranchTarget};
            valid_next = 1'b0;
`ifdef FETCH_NOP_DELAY_EN
            state_next = S_FETCH;
            count_next = '0;
`endif
        end else if (iStall && oValid) begin
            // Execute is holding the live instruction; keep everything as is.
            pc_next = pc;
`ifdef FETCH_NOP_DELAY_EN
        end else if (state == S_WAIT) begin
            valid_next = 1'b0;
            count_next = count - 24'd1;
            if (count == 24'd1) begin
                state_next = S_FETCH;
            end
`endif
        end else begin
            pc_next = pc + 16'd1;
            if (iInstruction[27:24] == OP_JMP) begin
                // Jumps are folded here and never reach execute.
                pc_next    = {8'd0, iInstruction[23:16]};
                valid_next = 1'b0;
`ifdef FETCH_NOP_DELAY_EN
            end else if (iInstruction[27:24] == OP_NOP) begin
                // The fetch edge itself is the first bubble; WAIT adds the remaining N.
                valid_next = 1'b0;
                if (iInstruction[23:0] != 24'd0) begin
                    count_next = iInstruction[23:0];
                    state_next = S_WAIT;
                end
`endif
            end else begin
                instr_next = iInstruction;
                opc_next   = pc;
                valid_next = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pc           <= RESET_PC;
            oInstruction <= '0;
            oValid       <= 1'b0;
            oPC          <= '0;
`ifdef FETCH_NOP_DELAY_EN
            state        <= S_FETCH;
            count        <= '0;
`endif
        end else begin
            pc           <= pc_next;
            oInstruction <= instr_next;
            oValid       <= valid_next;
            oPC          <= opc_next;
`ifdef FETCH_NOP_DELAY_EN
            state        <= state_next;
            count        <= count_next;
`endif
        end
    end

endmodule
